mvm_loader: RTL and testbench

Write-side companion to the MVM control FSM: accepts a load command, then consumes a valid/ready stream of data words and writes them to sequential addresses in either the vector memory or one output lane's matrix memory. It fills the memories that the control FSM later reads with `vec_raddr`/`mat_raddr`. One command at a time, with a single-cycle `done` pulse on completion.

---
 rtl/mvm_pkg.sv | 21 ++
 rtl/mvm_loader.sv | 143 ++++++++++++++
 tb/tb_mvm_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mvm_pkg.sv
// Shared types and widths for the MVM control FSM and its memory loader.
// Both sides must agree on address and word-count widths.
package mvm_pkg;

    localparam int MVM_DATAW      = 64;
    localparam int MVM_NUM_OLANES = 8;
    localparam int MVM_VEC_ADDRW  = 8;
    localparam int MVM_MAT_ADDRW  = 9;
    localparam int MVM_MAT_SIZEW  = MVM_MAT_ADDRW + 1;

    typedef enum logic {
        TGT_VEC = 1'b0,
        TGT_MAT = 1'b1
    } target_t;

    typedef enum logic {
        LD_IDLE = 1'b0,
        LD_LOAD = 1'b1
    } loader_state_t;

endpackage

// File: rtl/mvm_loader.sv
// Streams data words into the vector memory or one matrix lane memory
// at consecutive (wrapping) addresses, one command at a time.
module mvm_loader
    import mvm_pkg::*;
#(
    parameter int DATAW      = MVM_DATAW,
    parameter int NUM_OLANES = MVM_NUM_OLANES,
    parameter int VEC_ADDRW  = MVM_VEC_ADDRW,
    parameter int MAT_ADDRW  = MVM_MAT_ADDRW,
    parameter int MAT_SIZEW  = MAT_ADDRW + 1,
    parameter int LANEW      = $clog2(NUM_OLANES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_target,
    input  logic [LANEW-1:0]      cmd_lane,
    input  logic [MAT_ADDRW-1:0]  cmd_start_addr,
    input  logic [MAT_SIZEW-1:0]  cmd_num_words,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [DATAW-1:0]      i_data,
    output logic                  vec_wen,
    output logic [VEC_ADDRW-1:0]  vec_waddr,
    output logic [NUM_OLANES-1:0] mat_wen,
    output logic [MAT_ADDRW-1:0]  mat_waddr,
    output logic [DATAW-1:0]      wdata,
    output logic                  busy,
    output logic                  done
);

    loader_state_t state_q, state_d;

    target_t               tgt_q;
    logic [LANEW-1:0]      lane_q;
    logic [MAT_ADDRW-1:0]  start_q;
    logic [MAT_SIZEW-1:0]  count_q;
    logic [MAT_SIZEW-1:0]  idx_q;

    logic                  vec_wen_q, vec_wen_d;
    logic [NUM_OLANES-1:0] mat_wen_q, mat_wen_d;
    logic [MAT_ADDRW-1:0]  waddr_q, waddr_d;
    logic [DATAW-1:0]      wdata_q;
    logic                  done_q, done_d;
    logic                  busy_q;

    logic cmd_fire;
    logic data_fire;
    logic last;

    // cmd_ready is held low while reset is asserted
    assign cmd_ready = rst & (state_q == LD_IDLE);
    assign i_ready   = (state_q == LD_LOAD);
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign data_fire = i_valid & i_ready;
    assign last      = (idx_q == count_q - MAT_SIZEW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_wen_d = 1'b0;
        mat_wen_d = '0;
        done_d    = 1'b0;
        waddr_d   = start_q + idx_q[MAT_ADDRW-1:0];
        unique case (state_q)
            LD_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_num_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = LD_LOAD;
                    end
                end
            end
            LD_LOAD: begin
                if (data_fire) begin
                    if (tgt_q == TGT_VEC) begin
                        vec_wen_d = 1'b1;
                    end else begin
                        mat_wen_d = NUM_OLANES'(1) << lane_q;
                    end
                    if (last) begin
                        done_d  = 1'b1;
                        state_d = LD_IDLE;
                    end
                end
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_q     <= TGT_VEC;
            lane_q    <= '0;
            start_q   <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            vec_wen_q <= 1'b0;
            mat_wen_q <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            if (cmd_fire) begin
                tgt_q   <= target_t'(cmd_target);
                lane_q  <= cmd_lane;
                start_q <= cmd_start_addr;
                count_q <= cmd_num_words;
                idx_q   <= '0;
            end else if (data_fire) begin
                idx_q <= idx_q + MAT_SIZEW'(1);
            end
            if (data_fire) begin
                waddr_q <= waddr_d;
                wdata_q <= i_data;
            end
            vec_wen_q <= vec_wen_d;
            mat_wen_q <= mat_wen_d;
            done_q    <= done_d;
            // stays high through the cycle carrying the final write
            busy_q    <= (state_d == LD_LOAD) | vec_wen_d | (|mat_wen_d);
        end
    end

    assign vec_wen   = vec_wen_q;
    assign vec_waddr = waddr_q[VEC_ADDRW-1:0];
    assign mat_wen   = mat_wen_q;
    assign mat_waddr = waddr_q;
    assign wdata     = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mvm_loader.sv
// Directed bench for mvm_loader with a write scoreboard.
// Expected writes are queued at each data handshake and popped on output.
module tb_mvm_loader;
    import mvm_pkg::*;

    localparam int DW  = 64;
    localparam int NL  = 8;
    localparam int VAW = 8;
    localparam int MAW = 9;
    localparam int MSW = 10;
    localparam int LW  = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cmd_target = 1'b0;
    logic [LW-1:0]  cmd_lane = '0;
    logic [MAW-1:0] cmd_start_addr = '0;
    logic [MSW-1:0] cmd_num_words = '0;
    logic           i_valid = 1'b0;
    logic           i_ready;
    logic [DW-1:0]  i_data = '0;
    logic           vec_wen;
    logic [VAW-1:0] vec_waddr;
    logic [NL-1:0]  mat_wen;
    logic [MAW-1:0] mat_waddr;
    logic [DW-1:0]  wdata;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    mvm_loader dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_target     (cmd_target),
        .cmd_lane       (cmd_lane),
        .cmd_start_addr (cmd_start_addr),
        .cmd_num_words  (cmd_num_words),
        .i_valid        (i_valid),
        .i_ready        (i_ready),
        .i_data         (i_data),
        .vec_wen        (vec_wen),
        .vec_waddr      (vec_waddr),
        .mat_wen        (mat_wen),
        .mat_waddr      (mat_waddr),
        .wdata          (wdata),
        .busy           (busy),
        .done           (done)
    );

    typedef struct packed {
        logic           is_mat;
        logic [NL-1:0]  men;
        logic [MAW-1:0] addr;
        logic [DW-1:0]  data;
        logic           last;
    } wr_t;

    wr_t sb[$];
    int  zero_done = 0;
    int  passed = 0;
    int  total = 0;
    bit  mon_en = 1'b0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst) begin
            wr_t e;
            if (vec_wen || (mat_wen != '0)) begin
                if (sb.size() == 0) begin
                    chk("spurious_wr", {vec_wen, mat_wen}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("vec_wen", vec_wen, !e.is_mat);
                    chk("mat_wen", mat_wen, e.is_mat ? e.men : '0);
                    chk("waddr", e.is_mat ? mat_waddr : {1'b0, vec_waddr},
                        e.addr);
                    chk("wdata", wdata, e.data);
                    chk("done_wr", done, e.last);
                    chk("busy_wr", busy, 1);
                end
            end else if (zero_done > 0) begin
                chk("done_zero", done, 1);
                zero_done--;
            end else begin
                chk("done_idle", done, 0);
            end
        end
    end

    task automatic issue_cmd(bit tgt, int lane, int start, int n);
        int to = 0;
        cmd_valid      = 1'b1;
        cmd_target     = tgt;
        cmd_lane       = LW'(lane);
        cmd_start_addr = MAW'(start);
        cmd_num_words  = MSW'(n);
        while (!cmd_ready && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (!cmd_ready) chk("cmd_ready_to", cmd_ready, 1);
        @(posedge clk);
        if (n == 0) zero_done++;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_words(bit tgt, int lane, int start,
                              int cnt, int nsend, int gap_at);
        for (int i = 0; i < nsend; i++) begin
            int  to = 0;
            wr_t e;
            if (i == gap_at) begin
                i_valid = 1'b0;
                @(negedge clk);
            end
            i_valid = 1'b1;
            i_data  = {$urandom, $urandom};
            while (!i_ready && to < 50) begin
                @(negedge clk);
                to++;
            end
            if (!i_ready) chk("i_ready_to", i_ready, 1);
            @(posedge clk);
            e.is_mat = tgt;
            e.men    = tgt ? (NL'(1) << lane) : '0;
            e.addr   = tgt ? MAW'(start + i) : MAW'((start + i) & 255);
            e.data   = i_data;
            e.last   = (i == cnt - 1);
            sb.push_back(e);
            @(negedge clk);
        end
        i_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wen", {vec_wen, mat_wen}, 0);
        chk("rst_addr", {vec_waddr, mat_waddr}, 0);
        chk("rst_wdata", wdata, 0);
        rst    = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", cmd_ready, 1);

        // vector load, back-to-back data
        issue_cmd(1'b0, 0, 'h10, 4);
        chk("v_busy", busy, 1);
        chk("v_i_ready", i_ready, 1);
        chk("v_cmd_ready", cmd_ready, 0);
        send_words(1'b0, 0, 'h10, 4, 4, -1);
        repeat (3) @(negedge clk);
        chk("v_busy_after", busy, 0);

        // matrix lane 5, wrapping address, one valid gap
        issue_cmd(1'b1, 5, 'h1FE, 3);
        send_words(1'b1, 5, 'h1FE, 3, 3, 1);
        repeat (3) @(negedge clk);

        // zero-length command
        issue_cmd(1'b0, 0, 'h20, 0);
        chk("z_busy0", busy, 0);
        @(negedge clk);
        chk("z_busy1", busy, 0);
        repeat (2) @(negedge clk);

        // back-to-back commands
        issue_cmd(1'b0, 0, 'h30, 2);
        send_words(1'b0, 0, 'h30, 2, 2, -1);
        chk("ovl_ready", cmd_ready, 1);
        chk("ovl_busy", busy, 1);
        issue_cmd(1'b1, 0, 'h40, 2);
        chk("ovl_gap", {vec_wen, mat_wen}, 0);
        chk("ovl_busy2", busy, 1);
        send_words(1'b1, 0, 'h40, 2, 2, -1);
        repeat (3) @(negedge clk);

        // command fields change during a load and must be ignored
        issue_cmd(1'b1, 2, 'h100, 3);
        cmd_valid      = 1'b1;
        cmd_target     = 1'b0;
        cmd_lane       = 3'd7;
        cmd_start_addr = 9'h055;
        cmd_num_words  = 10'd1;
        send_words(1'b1, 2, 'h100, 3, 3, -1);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);

        // reset in the middle of a load
        issue_cmd(1'b0, 0, 'h60, 6);
        send_words(1'b0, 0, 'h60, 6, 2, -1);
        i_valid = 1'b1;
        i_data  = {$urandom, $urandom};
        #2 rst = 1'b0;
        #1;
        chk("mr_cmd_ready", cmd_ready, 0);
        chk("mr_i_ready", i_ready, 0);
        chk("mr_wen", {vec_wen, mat_wen}, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_addr", {vec_waddr, mat_waddr}, 0);
        chk("mr_wdata", wdata, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_rel_ready", cmd_ready, 1);
        chk("mr_rel_i_ready", i_ready, 0);
        repeat (6) @(negedge clk);
        i_valid = 1'b0;
        repeat (2) @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        chk("zero_done_left", zero_done, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
